// File: rtl/mdu_unit_pkg.sv
// Shared MDU definitions: operation encoding and op-class helpers.
package mdu_unit_pkg;

    typedef enum logic [3:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MFHI  = 4'd5,
        MDU_MFLO  = 4'd6,
        MDU_MTHI  = 4'd7,
        MDU_MTLO  = 4'd8
    } mdu_op_e;

    // True for the multi-cycle arithmetic ops that occupy the unit.
    function automatic logic is_muldiv(input logic [3:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) ||
               (op == MDU_DIV)  || (op == MDU_DIVU);
    endfunction

    // True for the divide ops (longer busy period).
    function automatic logic is_div(input logic [3:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_unit_calc.sv
// Combinational MDU datapath: produces the {hi,lo} result of mult/div,
// including divide-by-zero (keep HI/LO) and signed overflow rules.
module mdu_calc
    import mdu_unit_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] cur_hi,
    input  logic [31:0] cur_lo,
    output logic [63:0] result
);

    logic [63:0]        prod_s;
    logic [63:0]        prod_u;
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic signed [31:0] quot_s;
    logic signed [31:0] rem_s;
    logic [31:0]        quot_u;
    logic [31:0]        rem_u;

    // Compute every candidate result, then select by op.
    always_comb begin
        sa     = a;
        sb     = b;
        prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        prod_u = {32'd0, a} * {32'd0, b};
        quot_s = '0;
        rem_s  = '0;
        quot_u = '0;
        rem_u  = '0;
        if (b != '0) begin
            quot_u = a / b;
            rem_u  = a % b;
            if ((a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) begin
                quot_s = sa;
                rem_s  = '0;
            end else begin
                quot_s = sa / sb;
                rem_s  = sa % sb;
            end
        end

        result = {cur_hi, cur_lo};
        case (op)
            MDU_MULT:  result = prod_s;
            MDU_MULTU: result = prod_u;
            MDU_DIV:   if (b != '0) result = {rem_s, quot_s};
            MDU_DIVU:  if (b != '0) result = {rem_u, quot_u};
            default:   result = {cur_hi, cur_lo};
        endcase
    end

endmodule

// File: rtl/mdu_unit.sv
// E-stage multiply/divide unit: HI/LO registers, busy sequencing and
// mthi/mtlo/mfhi/mflo handling. Results are computed at issue and held
// pending until the fixed busy period elapses.
module mdu_unit
    import mdu_unit_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  E_MDU_op,
    input  logic [31:0] E_A,
    input  logic [31:0] E_B,
    input  logic        Req,
    output logic        E_MDU_start,
    output logic        E_MDU_busy,
    output logic [31:0] E_MDU_out,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    logic [CNT_W-1:0] counter;
    logic [31:0]      pending_hi;
    logic [31:0]      pending_lo;
    logic [63:0]      calc_result;

    mdu_calc u_calc (
        .op     (E_MDU_op),
        .a      (E_A),
        .b      (E_B),
        .cur_hi (HI),
        .cur_lo (LO),
        .result (calc_result)
    );

    // Accept a mult/div only when idle and not cancelled by an exception.
    always_comb begin
        E_MDU_start = is_muldiv(E_MDU_op) && !Req && !E_MDU_busy;
    end

    // Combinational read port for mfhi/mflo.
    always_comb begin
        E_MDU_out = '0;
        if (E_MDU_op == MDU_MFHI)      E_MDU_out = HI;
        else if (E_MDU_op == MDU_MFLO) E_MDU_out = LO;
    end

    // Busy countdown, pending-result commit and mthi/mtlo writes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            HI         <= '0;
            LO         <= '0;
            counter    <= '0;
            E_MDU_busy <= 1'b0;
            pending_hi <= '0;
            pending_lo <= '0;
        end else if (E_MDU_busy) begin
            if (counter == CNT_W'(1)) begin
                HI         <= pending_hi;
                LO         <= pending_lo;
                E_MDU_busy <= 1'b0;
                counter    <= '0;
            end else begin
                counter <= counter - CNT_W'(1);
            end
        end else if (E_MDU_start) begin
            pending_hi <= calc_result[63:32];
            pending_lo <= calc_result[31:0];
            counter    <= is_div(E_MDU_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            E_MDU_busy <= 1'b1;
        end else if (!Req) begin
            if (E_MDU_op == MDU_MTHI) HI <= E_A;
            if (E_MDU_op == MDU_MTLO) LO <= E_A;
        end
    end

endmodule
